// File: rtl/haar_stage_evaluator.sv
// Haar cascade stage evaluator: streams per-classifier parameter words, requests one feature per
// classifier, accumulates leaf values and compares the stage sum against a streamed threshold.
// Optional end-marker framing check is compiled in with HAAR_FRAME_CHECK_EN.
module haar_stage_evaluator #(
  parameter int NUM_CLASSIFIERS_STAGE    = 32,
  parameter int NUM_PARAM_PER_CLASSIFIER = 18,
  parameter int NUM_STAGE_THRESHOLD      = 3,
  parameter int DATA_WIDTH_12            = 12,
  parameter int DATA_WIDTH_16            = 16,
  parameter int ACC_WIDTH                = 20
) (
  input  logic                          clk_fpga,
  input  logic                          reset_fpga,
  input  logic                          i_start,
  input  logic [DATA_WIDTH_12-1:0]      i_data,
  input  logic                          i_valid,
  input  logic                          i_end_single_classifier,
  input  logic                          i_end_database,
  output logic                          o_rden,
  output logic                          o_feat_req,
  output logic [15*DATA_WIDTH_12-1:0]   o_rect,
  input  logic                          i_feat_ack,
  input  logic [DATA_WIDTH_16-1:0]      i_feat_value,
  output logic                          o_busy,
  output logic                          o_stage_valid,
  output logic                          o_stage_pass,
  output logic [ACC_WIDTH-1:0]          o_stage_sum,
  output logic                          o_error
);

  localparam int IDX_MAX = (NUM_PARAM_PER_CLASSIFIER > NUM_STAGE_THRESHOLD) ?
                           NUM_PARAM_PER_CLASSIFIER : NUM_STAGE_THRESHOLD;
  localparam int IDX_W   = $clog2(IDX_MAX);
  localparam int CNT_W   = $clog2(NUM_CLASSIFIERS_STAGE + 1);
  localparam int THR_W   = DATA_WIDTH_12 + 4;

  typedef enum logic [2:0] {IDLE, LOAD, FEATURE, ACCUM, THRESH, DECIDE} state_t;

  state_t                   state;
  logic [IDX_W-1:0]         word_idx;
  logic [CNT_W-1:0]         cls_cnt;
  logic [ACC_WIDTH-1:0]     acc;
  logic [DATA_WIDTH_12-1:0] words [NUM_PARAM_PER_CLASSIFIER];
  logic [DATA_WIDTH_12-1:0] thr_lo;
  logic [3:0]               thr_hi;
  logic [DATA_WIDTH_16-1:0] feat_val;

  logic                     word_acc;
  logic                     cls_last;
  logic                     thr_last;
  logic                     acc_last;
  logic                     take_left;
  logic                     frame_abort;
  logic [DATA_WIDTH_16-1:0] w15_ext;
  logic [ACC_WIDTH-1:0]     left_ext;
  logic [ACC_WIDTH-1:0]     right_ext;
  logic [ACC_WIDTH-1:0]     leaf_ext;
  logic [ACC_WIDTH-1:0]     thr_ext;

  assign word_acc = i_valid && o_rden;
  assign cls_last = (word_idx == IDX_W'(NUM_PARAM_PER_CLASSIFIER - 1));
  assign thr_last = (word_idx == IDX_W'(NUM_STAGE_THRESHOLD - 1));
  assign acc_last = (cls_cnt == CNT_W'(NUM_CLASSIFIERS_STAGE - 1));

  // Node threshold and leaf values are signed 12-bit words widened to the compare/sum widths.
  assign w15_ext   = {{(DATA_WIDTH_16-DATA_WIDTH_12){words[15][DATA_WIDTH_12-1]}}, words[15]};
  assign left_ext  = {{(ACC_WIDTH-DATA_WIDTH_12){words[16][DATA_WIDTH_12-1]}}, words[16]};
  assign right_ext = {{(ACC_WIDTH-DATA_WIDTH_12){words[17][DATA_WIDTH_12-1]}}, words[17]};
  assign take_left = ($signed(feat_val) < $signed(w15_ext));
  assign leaf_ext  = take_left ? left_ext : right_ext;
  assign thr_ext   = {{(ACC_WIDTH-THR_W){thr_hi[3]}}, thr_hi, thr_lo};

  for (genvar g = 0; g < 15; g++) begin : g_rect
    assign o_rect[g*DATA_WIDTH_12 +: DATA_WIDTH_12] = words[g];
  end

`ifdef HAAR_FRAME_CHECK_EN
  logic frame_bad;

  always_comb begin
    frame_bad = 1'b0;
    if (state == LOAD)
      frame_bad = (i_end_single_classifier != cls_last) || i_end_database;
    else if (state == THRESH)
      frame_bad = (i_end_database != thr_last) || i_end_single_classifier;
  end

  assign frame_abort = word_acc && frame_bad;

  always_ff @(posedge clk_fpga) begin
    if (reset_fpga)
      o_error <= 1'b0;
    else
      o_error <= frame_abort;
  end
`else
  logic unused_markers;

  assign unused_markers = ^{i_end_single_classifier, i_end_database};
  assign frame_abort    = 1'b0;
  assign o_error        = 1'b0;
`endif

  always_ff @(posedge clk_fpga) begin
    if (reset_fpga) begin
      state         <= IDLE;
      word_idx      <= '0;
      cls_cnt       <= '0;
      acc           <= '0;
      thr_lo        <= '0;
      thr_hi        <= '0;
      feat_val      <= '0;
      for (int i = 0; i < NUM_PARAM_PER_CLASSIFIER; i++) words[i] <= '0;
      o_busy        <= 1'b0;
      o_rden        <= 1'b0;
      o_feat_req    <= 1'b0;
      o_stage_valid <= 1'b0;
      o_stage_pass  <= 1'b0;
      o_stage_sum   <= '0;
    end else if (frame_abort) begin
      state    <= IDLE;
      word_idx <= '0;
      o_busy   <= 1'b0;
      o_rden   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            state    <= LOAD;
            word_idx <= '0;
            cls_cnt  <= '0;
            acc      <= '0;
            o_busy   <= 1'b1;
            o_rden   <= 1'b1;
          end
        end

        LOAD: begin
          if (word_acc) begin
            words[word_idx] <= i_data;
            if (cls_last) begin
              word_idx   <= '0;
              o_rden     <= 1'b0;
              o_feat_req <= 1'b1;
              state      <= FEATURE;
            end else begin
              word_idx <= word_idx + 1'b1;
            end
          end
        end

        // o_rect is driven from words[], which cannot change outside LOAD.
        FEATURE: begin
          if (i_feat_ack) begin
            feat_val   <= i_feat_value;
            o_feat_req <= 1'b0;
            state      <= ACCUM;
          end
        end

        ACCUM: begin
          acc      <= acc + leaf_ext;
          cls_cnt  <= cls_cnt + 1'b1;
          word_idx <= '0;
          o_rden   <= 1'b1;
          state    <= acc_last ? THRESH : LOAD;
        end

        THRESH: begin
          if (word_acc) begin
            if (word_idx == IDX_W'(0)) thr_lo <= i_data;
            if (word_idx == IDX_W'(1)) thr_hi <= i_data[3:0];
            if (thr_last) begin
              word_idx      <= '0;
              o_rden        <= 1'b0;
              o_stage_valid <= 1'b1;
              o_stage_pass  <= ($signed(acc) >= $signed(thr_ext));
              o_stage_sum   <= acc;
              state         <= DECIDE;
            end else begin
              word_idx <= word_idx + 1'b1;
            end
          end
        end

        DECIDE: begin
          o_stage_valid <= 1'b0;
          o_busy        <= 1'b0;
          state         <= IDLE;
        end

        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
          o_rden <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_haar_stage_evaluator.sv
// Directed bench for haar_stage_evaluator: a 2-classifier and a 32-classifier instance share one
// word stream and one feature responder; sel chooses which instance the drivers talk to.
`timescale 1ns/1ps
module tb_haar_stage_evaluator;

  logic         clk_fpga;
  logic         reset_fpga;
  logic         start;
  logic         sel;
  logic [11:0]  i_data;
  logic         i_valid;
  logic         i_es;
  logic         i_ed;
  logic         i_feat_ack;
  logic [15:0]  i_feat_value;

  logic         a_rden, a_req, a_busy, a_valid, a_pass, a_err;
  logic [179:0] a_rect;
  logic [19:0]  a_sum;
  logic         b_rden, b_req, b_busy, b_valid, b_pass, b_err;
  logic [179:0] b_rect;
  logic [19:0]  b_sum;

  logic         start_a, start_b;
  logic         rden_s, req_s, busy_s, valid_s, pass_s, err_s;
  logic [179:0] rect_s;
  logic [19:0]  sum_s;

  assign start_a = start && !sel;
  assign start_b = start && sel;
  assign rden_s  = sel ? b_rden  : a_rden;
  assign req_s   = sel ? b_req   : a_req;
  assign busy_s  = sel ? b_busy  : a_busy;
  assign valid_s = sel ? b_valid : a_valid;
  assign pass_s  = sel ? b_pass  : a_pass;
  assign err_s   = sel ? b_err   : a_err;
  assign rect_s  = sel ? b_rect  : a_rect;
  assign sum_s   = sel ? b_sum   : a_sum;

  haar_stage_evaluator #(.NUM_CLASSIFIERS_STAGE(2)) u_dut2 (
    .clk_fpga(clk_fpga), .reset_fpga(reset_fpga), .i_start(start_a), .i_data(i_data),
    .i_valid(i_valid), .i_end_single_classifier(i_es), .i_end_database(i_ed),
    .o_rden(a_rden), .o_feat_req(a_req), .o_rect(a_rect), .i_feat_ack(i_feat_ack),
    .i_feat_value(i_feat_value), .o_busy(a_busy), .o_stage_valid(a_valid),
    .o_stage_pass(a_pass), .o_stage_sum(a_sum), .o_error(a_err));

  haar_stage_evaluator #(.NUM_CLASSIFIERS_STAGE(32)) u_dut32 (
    .clk_fpga(clk_fpga), .reset_fpga(reset_fpga), .i_start(start_b), .i_data(i_data),
    .i_valid(i_valid), .i_end_single_classifier(i_es), .i_end_database(i_ed),
    .o_rden(b_rden), .o_feat_req(b_req), .o_rect(b_rect), .i_feat_ack(i_feat_ack),
    .i_feat_value(i_feat_value), .o_busy(b_busy), .o_stage_valid(b_valid),
    .o_stage_pass(b_pass), .o_stage_sum(b_sum), .o_error(b_err));

  initial begin
    clk_fpga = 1'b0;
    forever #5 clk_fpga = ~clk_fpga;
  end

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Word stream feeder state
  logic [11:0] s_dat[$];
  bit          s_es[$];
  bit          s_ed[$];
  int          s_ptr = 0;
  bit          prev_offer = 0;
  bit          gap_en = 0;
  bit          gap_ph = 0;

  // Feature responder state
  logic [15:0]  f_vals[$];
  int           f_ptr = 0;
  int           ack_delay = 0;
  int           wait_cnt = 0;
  bit           acked = 0;
  bit           snap_taken = 0;
  bit           first_taken = 0;
  bit           rect_changed = 0;
  logic [179:0] snap;
  logic [179:0] first_snap;

  // An offer made at a negedge with o_rden high is consumed at the following posedge.
  initial begin
    i_valid = 1'b0; i_data = '0; i_es = 1'b0; i_ed = 1'b0;
    forever begin
      @(negedge clk_fpga);
      if (prev_offer) s_ptr++;
      gap_ph = ~gap_ph;
      if (s_ptr < s_dat.size() && (!gap_en || gap_ph)) begin
        i_valid = 1'b1; i_data = s_dat[s_ptr]; i_es = s_es[s_ptr]; i_ed = s_ed[s_ptr];
      end else begin
        i_valid = 1'b0; i_es = 1'b0; i_ed = 1'b0;
      end
      prev_offer = i_valid && rden_s && !reset_fpga;
    end
  end

  initial begin
    i_feat_ack = 1'b0; i_feat_value = '0;
    forever begin
      @(negedge clk_fpga);
      if (acked) begin f_ptr++; acked = 0; end
      if (req_s && !reset_fpga) begin
        if (!snap_taken) begin
          snap = rect_s; snap_taken = 1;
          if (!first_taken) begin first_snap = rect_s; first_taken = 1; end
        end else if (rect_s !== snap) begin
          rect_changed = 1;
        end
        if (wait_cnt >= ack_delay && f_vals.size() > 0) begin
          i_feat_ack = 1'b1; i_feat_value = f_vals[f_ptr % f_vals.size()]; acked = 1;
        end else begin
          i_feat_ack = 1'b0; wait_cnt++;
        end
      end else begin
        i_feat_ack = 1'b0; wait_cnt = 0; snap_taken = 0;
      end
    end
  end

  // Classifier c word w (w<15) carries c*18+w+1; words 15..17 and the threshold come from args.
  task automatic load_stream(input bit use32, input int ncls, input logic [11:0] w15,
                             input logic [11:0] w16, input logic [11:0] w17,
                             input logic [15:0] thr, input int dly, input bit gap,
                             input bit bad_frame);
    @(posedge clk_fpga);
    sel = use32;
    s_dat.delete(); s_es.delete(); s_ed.delete();
    for (int c = 0; c < ncls; c++) begin
      for (int w = 0; w < 18; w++) begin
        s_dat.push_back(w == 15 ? w15 : w == 16 ? w16 : w == 17 ? w17 : 12'(c*18 + w + 1));
        s_es.push_back(bad_frame ? (w == 16) : (w == 17));
        s_ed.push_back(1'b0);
      end
    end
    s_dat.push_back(thr[11:0]);           s_es.push_back(1'b0); s_ed.push_back(1'b0);
    s_dat.push_back({8'hA5, thr[15:12]}); s_es.push_back(1'b0); s_ed.push_back(1'b0);
    s_dat.push_back(12'h777);             s_es.push_back(1'b0); s_ed.push_back(1'b1);
    s_ptr = 0; prev_offer = 0; f_ptr = 0; acked = 0; wait_cnt = 0;
    ack_delay = dly; gap_en = gap; rect_changed = 0; first_taken = 0; snap_taken = 0;
  endtask

  // Pulses start, then reports the cycle of o_stage_valid (start cycle = 1) and pulse counts.
  task automatic kick_and_wait(input bit restart, input bit stop_on_err,
                               output int lat, output int nval, output int nerr);
    int edges;
    @(negedge clk_fpga); start = 1'b1;
    @(negedge clk_fpga); start = 1'b0;
    edges = 1; lat = 0; nval = 0; nerr = 0;
    while (edges < 3000 && lat == 0 && !(stop_on_err && nerr > 0)) begin
      if (valid_s) begin nval++; lat = edges + 1; end
      if (err_s) nerr++;
      start = restart && (edges == 10);
      @(negedge clk_fpga);
      edges++;
    end
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_fpga);
      if (valid_s) nval++;
      if (err_s) nerr++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk_fpga); reset_fpga = 1'b1;
    @(negedge clk_fpga);
    @(negedge clk_fpga); reset_fpga = 1'b0;
  endtask

  logic [179:0] exp_rect;
  int lat, nval, nerr;
  bit seen;

  initial begin
    reset_fpga = 1'b1; start = 1'b0; sel = 1'b0;
    for (int w = 0; w < 15; w++) exp_rect[w*12 +: 12] = 12'(w + 1);
    f_vals = '{16'd50, 16'd200};
    do_reset();

    check_eq("rst_busy",  {a_busy, b_busy}, 2'b00);
    check_eq("rst_rden",  {a_rden, b_rden}, 2'b00);
    check_eq("rst_req",   {a_req, b_req}, 2'b00);
    check_eq("rst_valid", {a_valid, b_valid, a_pass, b_pass}, 4'b0000);
    check_eq("rst_sum",   {a_sum, b_sum}, 40'h0);
    check_eq("rst_rect",  (a_rect == '0) && (b_rect == '0), 1'b1);
    check_eq("rst_err",   {a_err, b_err}, 2'b00);

    // 50<100 -> +5, 200>=100 -> -3: sum 2
    load_stream(0, 2, 12'd100, 12'd5, 12'hFFD, 16'd2, 0, 0, 0);
    kick_and_wait(0, 0, lat, nval, nerr);
    check_eq("a_latency", lat, 45);
    check_eq("a_nvalid", nval, 1);
    check_eq("a_sum", sum_s, 20'd2);
    check_eq("a_pass", pass_s, 1'b1);
    check_eq("a_noerr", nerr, 0);
    check_eq("a_idle", busy_s, 1'b0);
    check_eq("a_rect_words", first_snap == exp_rect, 1'b1);

    // Threshold one above the sum, and a start pulse while busy that must be ignored
    load_stream(0, 2, 12'd100, 12'd5, 12'hFFD, 16'd3, 0, 0, 0);
    kick_and_wait(1, 0, lat, nval, nerr);
    check_eq("b_latency", lat, 45);
    check_eq("b_nvalid", nval, 1);
    check_eq("b_sum", sum_s, 20'd2);
    check_eq("b_pass", pass_s, 1'b0);

    // Gapped stream and 7-cycle ack delay
    load_stream(0, 2, 12'd100, 12'd5, 12'hFFD, 16'd2, 7, 1, 0);
    kick_and_wait(0, 0, lat, nval, nerr);
    check_eq("c_done", lat != 0, 1'b1);
    check_eq("c_nvalid", nval, 1);
    check_eq("c_sum", sum_s, 20'd2);
    check_eq("c_pass", pass_s, 1'b1);
    check_eq("c_rect_stable", rect_changed, 1'b0);
    check_eq("c_rect_words", first_snap == exp_rect, 1'b1);

    // Reset while a feature request is outstanding
    load_stream(0, 2, 12'd100, 12'd5, 12'hFFD, 16'd2, 1000, 0, 0);
    @(negedge clk_fpga); start = 1'b1;
    @(negedge clk_fpga); start = 1'b0;
    seen = 0;
    for (int k = 0; k < 100 && !seen; k++) begin
      if (req_s) seen = 1; else @(negedge clk_fpga);
    end
    check_eq("d_req_rise", seen, 1'b1);
    repeat (3) @(negedge clk_fpga);
    check_eq("d_req_held", {req_s, rden_s, busy_s}, 3'b101);
    reset_fpga = 1'b1;
    @(negedge clk_fpga); reset_fpga = 1'b0;
    check_eq("d_rst_state", {busy_s, rden_s, req_s, valid_s, pass_s}, 5'b00000);
    check_eq("d_rst_sum", sum_s, 20'd0);
    check_eq("d_rst_rect", rect_s == '0, 1'b1);
    load_stream(0, 2, 12'd100, 12'd5, 12'hFFD, 16'd2, 0, 0, 0);
    kick_and_wait(0, 0, lat, nval, nerr);
    check_eq("d_latency", lat, 45);
    check_eq("d_nvalid", nval, 1);
    check_eq("d_sum", sum_s, 20'd2);
    check_eq("d_pass", pass_s, 1'b1);

    // Signed compare: -5 >= -100 -> +7; -300 < -100 -> -2048; sum -2041
    f_vals = '{16'hFFFB, 16'hFED4};
    load_stream(0, 2, 12'hF9C, 12'h800, 12'd7, 16'hF807, 0, 0, 0);
    kick_and_wait(0, 0, lat, nval, nerr);
    check_eq("e_sum", sum_s, 20'hFF807);
    check_eq("e_pass_eq", pass_s, 1'b1);
    load_stream(0, 2, 12'hF9C, 12'h800, 12'd7, 16'hF808, 0, 0, 0);
    kick_and_wait(0, 0, lat, nval, nerr);
    check_eq("e_sum2", sum_s, 20'hFF807);
    check_eq("e_pass_above", pass_s, 1'b0);

    // 32 classifiers all taking -2048: sum -65536 against the most negative threshold -32768
    f_vals = '{16'd0};
    load_stream(1, 32, 12'd100, 12'h800, 12'd5, 16'h8000, 0, 0, 0);
    kick_and_wait(0, 0, lat, nval, nerr);
    check_eq("f_latency", lat, 645);
    check_eq("f_nvalid", nval, 1);
    check_eq("f_sum", sum_s, 20'hF0000);
    check_eq("f_pass", pass_s, 1'b0);
    check_eq("f_noerr", nerr, 0);

`ifdef HAAR_FRAME_CHECK_EN
    f_vals = '{16'd50, 16'd200};
    load_stream(0, 2, 12'd100, 12'd5, 12'hFFD, 16'd2, 0, 0, 1);
    kick_and_wait(0, 1, lat, nval, nerr);
    check_eq("g_err_pulse", nerr, 1);
    check_eq("g_nvalid", nval, 0);
    check_eq("g_idle", {busy_s, rden_s}, 2'b00);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
